// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers
//   of the MIPS datapath. Runs MULT, MULTU, DIV and DIVU one bit per cycle
//   (WIDTH iterations), then spends one FINISH cycle applying the sign fix
//   and writing HI/LO. MTHI/MTLO write HI/LO directly while idle.
//
// Ports
//   clk     in   1      system clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      begin the operation selected by op (sampled in IDLE)
//   op      in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a       in   WIDTH  rs operand (multiplicand / dividend)
//   b       in   WIDTH  rt operand (multiplier / divisor)
//   mthi    in   1      write wdata into HI (idle only)
//   mtlo    in   1      write wdata into LO (idle only)
//   wdata   in   WIDTH  data for MTHI/MTLO
//   busy    out  1      operation in flight; pipeline must stall
//   done    out  1      one-cycle pulse, HI/LO just updated with a result
//   hi      out  WIDTH  HI register (product high / remainder)
//   lo      out  WIDTH  LO register (product low / quotient)
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // State and datapath registers
  logic [1:0]         state_q,   state_d;
  logic               is_div_q,  is_div_d;
  logic               res_neg_q, res_neg_d;  // negate product / quotient
  logic               rem_neg_q, rem_neg_d;  // negate remainder (sign of a)
  logic               b_zero_q,  b_zero_d;   // divide-by-zero flag
  logic [WIDTH-1:0]   dvsr_q,    dvsr_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q,     acc_d;      // {hi-half, lo-half} working register
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               done_q,    done_d;

  // Operand magnitudes; sign flags are only meaningful for signed ops (op[0]).
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  // The most negative value maps onto itself, which read as unsigned is the
  // correct magnitude.
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Shift-add multiply step: the multiplier sits in the low half and is
  // consumed LSB first while partial sums enter from the top, so after WIDTH
  // steps acc holds the full 2*WIDTH-bit product.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, dvsr_q} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: the partial remainder lives in the high half, the
  // dividend shifts out of the low half MSB first and quotient bits shift in
  // at the bottom. The shifted remainder needs WIDTH+1 bits, the trial
  // difference one more for its borrow.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ok;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, dvsr_q};
  assign div_ok    = ~div_diff[WIDTH+1];
  // On a failed trial the shifted remainder is below the divisor, so its top
  // bit is zero and dropping it loses nothing.
  assign div_rem   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ok};

  // Sign fix-up applied in FINISH
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
  // Divide by zero yields an all-ones quotient regardless of signs; the
  // remainder path already reproduces a (magnitude then sign of a).
  assign quo_fix  = b_zero_q  ? {WIDTH{1'b1}} :
                    res_neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                              : acc_q[2*WIDTH-1:WIDTH];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
    dvsr_d    = dvsr_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // start has priority over a simultaneous MTHI/MTLO
          state_d   = S_CALC;
          is_div_d  = op[1];
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          b_zero_d  = (b == '0);
          cnt_d     = '0;
          if (op[1]) begin
            dvsr_d = b_mag;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
          end else begin
            dvsr_d = a_mag;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FINISH;
      end

      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      dvsr_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
      dvsr_q    <= dvsr_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // busy drops in the same cycle done pulses, so back-to-back starts work.
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
